// File: rtl/ipv4_builder.sv
// Transmit-side IPv4 header generator: emits a 20-byte header (IHL=5) followed by pass-through payload.
// Define IPV4_BUILDER_CSUM_EN to compute the header checksum in an extra CSUM cycle; otherwise it is 0x0000.
module ipv4_builder #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter logic [7:0]  TTL        = 8'd64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              hdr_valid_in,
   output logic                              hdr_ready_out,
   input  logic [31:0]                       src_ip,
   input  logic [31:0]                       dst_ip,
   input  logic [7:0]                        protocol,
   input  logic [15:0]                       payload_len,
   input  logic [DATA_WIDTH-1:0]             tdata_in,
   input  logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_in,
   input  logic                              data_valid_in,
   input  logic                              last_flag_in,
   output logic                              payload_ready,
   output logic [DATA_WIDTH-1:0]             tdata_out,
   output logic [$clog2(DATA_WIDTH/8+1)-1:0] idx_out,
   output logic                              data_valid_out,
   output logic                              last_flag_out,
   input  logic                              tx_ready_in
);

   localparam int unsigned BYTES      = DATA_WIDTH / 8;
   localparam int unsigned IW         = $clog2(BYTES + 1);
   localparam int unsigned HDR_BEATS  = (20 + BYTES - 1) / BYTES;
   localparam int unsigned LAST_BYTES = 20 - (HDR_BEATS - 1) * BYTES;
   localparam int unsigned BW         = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CSUM,
      S_HDR,
      S_PAY
   } state_t;

   state_t                state_q, state_d;
   logic                  hdr_ready_q, hdr_ready_d;
   logic [31:0]           src_q, src_d;
   logic [31:0]           dst_q, dst_d;
   logic [7:0]            proto_q, proto_d;
   logic [15:0]           total_len_q, total_len_d;
   logic                  len_zero_q, len_zero_d;
   logic [15:0]           ident_q, ident_d;
   logic [15:0]           pkt_ident_q, pkt_ident_d;
   logic [15:0]           csum_q, csum_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;

   logic                  load_en;
   logic                  hdr_fire;
   logic                  last_hdr_beat;
   logic [159:0]          hdr_vec;
   logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_pad;
   logic [DATA_WIDTH-1:0] hdr_beat;
   logic [IW-1:0]         hdr_idx;

   assign load_en       = !valid_q || tx_ready_in;
   assign hdr_fire      = hdr_valid_in && hdr_ready_q && (state_q == S_IDLE);
   assign last_hdr_beat = (beat_q == BW'(HDR_BEATS - 1));
   assign hdr_idx       = last_hdr_beat ? IW'(LAST_BYTES) : IW'(BYTES);

   assign hdr_ready_out  = hdr_ready_q;
   assign payload_ready  = (state_q == S_PAY) && load_en;
   assign tdata_out      = tdata_q;
   assign idx_out        = idx_q;
   assign data_valid_out = valid_q;
   assign last_flag_out  = last_q;

   // Header image, byte k at [k*8 +: 8]; multi-byte fields are big-endian on the wire.
   always_comb begin
      hdr_vec            = '0;
      hdr_vec[0 +: 8]    = 8'h45;
      hdr_vec[16 +: 8]   = total_len_q[15:8];
      hdr_vec[24 +: 8]   = total_len_q[7:0];
      hdr_vec[32 +: 8]   = pkt_ident_q[15:8];
      hdr_vec[40 +: 8]   = pkt_ident_q[7:0];
      hdr_vec[48 +: 8]   = 8'h40;
      hdr_vec[64 +: 8]   = TTL;
      hdr_vec[72 +: 8]   = proto_q;
      hdr_vec[80 +: 8]   = csum_q[15:8];
      hdr_vec[88 +: 8]   = csum_q[7:0];
      for (int unsigned b = 0; b < 4; b++) begin
         hdr_vec[(12 + b) * 8 +: 8] = src_q[(3 - b) * 8 +: 8];
         hdr_vec[(16 + b) * 8 +: 8] = dst_q[(3 - b) * 8 +: 8];
      end
   end

   always_comb begin
      hdr_pad          = '0;
      hdr_pad[159:0]   = hdr_vec;
      hdr_beat         = hdr_pad[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef IPV4_BUILDER_CSUM_EN
   logic [19:0] csum_sum;
   logic [16:0] csum_f1;
   logic [15:0] csum_f2;

   // Checksum field is zero while summing; two folds absorb every carry of the 20-bit sum.
   always_comb begin
      csum_sum = 20'(16'h4500) + 20'(total_len_q) + 20'(pkt_ident_q) + 20'(16'h4000)
               + 20'({TTL, proto_q}) + 20'(src_q[31:16]) + 20'(src_q[15:0])
               + 20'(dst_q[31:16]) + 20'(dst_q[15:0]);
      csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
      csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
   end
`endif

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      proto_d     = proto_q;
      total_len_d = total_len_q;
      len_zero_d  = len_zero_q;
      ident_d     = ident_q;
      pkt_ident_d = pkt_ident_q;
      csum_d      = csum_q;
      beat_d      = beat_q;
      tdata_d     = tdata_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      last_d      = last_q;

      if (load_en) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (hdr_fire) begin
               src_d       = src_ip;
               dst_d       = dst_ip;
               proto_d     = protocol;
               total_len_d = payload_len + 16'd20;
               len_zero_d  = (payload_len == 16'd0);
               pkt_ident_d = ident_q;
               ident_d     = ident_q + 16'd1;
               csum_d      = '0;
               beat_d      = '0;
`ifdef IPV4_BUILDER_CSUM_EN
               state_d     = S_CSUM;
`else
               state_d     = S_HDR;
`endif
            end
         end
         S_CSUM: begin
`ifdef IPV4_BUILDER_CSUM_EN
            csum_d  = ~csum_f2;
`endif
            state_d = S_HDR;
         end
         S_HDR: begin
            if (load_en) begin
               tdata_d = hdr_beat;
               idx_d   = hdr_idx;
               valid_d = 1'b1;
               last_d  = last_hdr_beat && len_zero_q;
               if (last_hdr_beat) begin
                  beat_d  = '0;
                  state_d = len_zero_q ? S_IDLE : S_PAY;
               end else begin
                  beat_d  = beat_q + BW'(1);
               end
            end
         end
         S_PAY: begin
            if (data_valid_in && load_en) begin
               tdata_d = tdata_in;
               idx_d   = idx_in;
               valid_d = 1'b1;
               last_d  = last_flag_in;
               if (last_flag_in) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      hdr_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hdr_ready_q <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         proto_q     <= '0;
         total_len_q <= '0;
         len_zero_q  <= 1'b0;
         ident_q     <= '0;
         pkt_ident_q <= '0;
         csum_q      <= '0;
         beat_q      <= '0;
         tdata_q     <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_ready_q <= hdr_ready_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         proto_q     <= proto_d;
         total_len_q <= total_len_d;
         len_zero_q  <= len_zero_d;
         ident_q     <= ident_d;
         pkt_ident_q <= pkt_ident_d;
         csum_q      <= csum_d;
         beat_q      <= beat_d;
         tdata_q     <= tdata_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
      end
   end

endmodule

// File: tb/tb_ipv4_builder.sv
// Directed bench for ipv4_builder (DATA_WIDTH=64): packet vector table plus reset, ident-wrap and abort sequences.
module tb_ipv4_builder;

`ifdef IPV4_BUILDER_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
   localparam int LAT     = 3;
`else
   localparam bit CSUM_ON = 1'b0;
   localparam int LAT     = 2;
`endif

   logic        clk;
   logic        rst_n;
   logic        hdr_valid_in;
   logic        hdr_ready_out;
   logic [31:0] src_ip;
   logic [31:0] dst_ip;
   logic [7:0]  protocol;
   logic [15:0] payload_len;
   logic [63:0] tdata_in;
   logic [3:0]  idx_in;
   logic        data_valid_in;
   logic        last_flag_in;
   logic        payload_ready;
   logic [63:0] tdata_out;
   logic [3:0]  idx_out;
   logic        data_valid_out;
   logic        last_flag_out;
   logic        tx_ready_in;

   ipv4_builder #(.DATA_WIDTH(64), .TTL(8'd64)) dut (
      .clk(clk), .rst_n(rst_n),
      .hdr_valid_in(hdr_valid_in), .hdr_ready_out(hdr_ready_out),
      .src_ip(src_ip), .dst_ip(dst_ip), .protocol(protocol), .payload_len(payload_len),
      .tdata_in(tdata_in), .idx_in(idx_in), .data_valid_in(data_valid_in),
      .last_flag_in(last_flag_in), .payload_ready(payload_ready),
      .tdata_out(tdata_out), .idx_out(idx_out), .data_valid_out(data_valid_out),
      .last_flag_out(last_flag_out), .tx_ready_in(tx_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [7:0]  proto;
      logic [15:0] len;
      int          pbytes;
      bit          mid_part;
      int          s1;
      int          s2;
      logic [15:0] ident;
      logic [15:0] csum;
   } vec_t;

   vec_t        tv[5];
   vec_t        vw;
   int          nvec = 0;
   int          nmis = 0;

   logic [63:0] pay_data[16];
   logic [3:0]  pay_idx[16];
   int          npay;
   logic [63:0] out_d[$];
   logic [3:0]  out_i[$];
   logic        out_l[$];
   int          hcyc;
   int          fcyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] lane_mask(input logic [3:0] n);
      lane_mask = '0;
      for (int i = 0; i < 8; i++) if (i < int'(n)) lane_mask[i*8 +: 8] = 8'hFF;
   endfunction

   function automatic logic [7:0] hbyte(input int k, input vec_t v, input logic [15:0] cs);
      logic [15:0] tot;
      logic [31:0] sh;
      tot = v.len + 16'd20;
      case (k)
         0: hbyte = 8'h45;
         1: hbyte = 8'h00;
         2: hbyte = tot[15:8];
         3: hbyte = tot[7:0];
         4: hbyte = v.ident[15:8];
         5: hbyte = v.ident[7:0];
         6: hbyte = 8'h40;
         7: hbyte = 8'h00;
         8: hbyte = 8'd64;
         9: hbyte = v.proto;
         10: hbyte = cs[15:8];
         11: hbyte = cs[7:0];
         12, 13, 14, 15: begin sh = v.src >> (8 * (15 - k)); hbyte = sh[7:0]; end
         16, 17, 18, 19: begin sh = v.dst >> (8 * (19 - k)); hbyte = sh[7:0]; end
         default: hbyte = 8'h00;
      endcase
   endfunction

   task automatic build_payload(input int pbytes, input bit mid_part, input int seed);
      int rem, sz, bc;
      npay = 0;
      rem  = pbytes;
      bc   = seed;
      while (rem > 0) begin
         sz = (npay == 0 && mid_part && rem > 3) ? 3 : ((rem > 8) ? 8 : rem);
         pay_data[npay] = '0;
         for (int i = 0; i < sz; i++) begin
            pay_data[npay][i*8 +: 8] = 8'(bc * 7 + 3);
            bc++;
         end
         pay_idx[npay] = 4'(sz);
         npay++;
         rem -= sz;
      end
   endtask

   // Runs one packet cycle by cycle; inputs change #1 after posedge, outputs sampled at negedge.
   task automatic run_packet(input vec_t v, input int abort_after);
      int  pi;
      bit  done, hdr_fire, pay_fire, hold_v, hold_l, rdy;
      logic [63:0] hold_d;
      logic [3:0]  hold_i;
      int  rel;
      out_d.delete(); out_i.delete(); out_l.delete();
      hcyc = -1; fcyc = -1; pi = 0; done = 0; hold_v = 0;
      hold_d = '0; hold_i = '0; hold_l = 0;
      src_ip = v.src; dst_ip = v.dst; protocol = v.proto; payload_len = v.len;
      hdr_valid_in  = 1'b1;
      data_valid_in = (npay > 0);
      tdata_in      = pay_data[0];
      idx_in        = pay_idx[0];
      last_flag_in  = (npay == 1);
      tx_ready_in   = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (hold_v) begin
            chk("hold_valid", {63'd0, data_valid_out}, 64'd1);
            chk("hold_data", tdata_out, hold_d);
            chk("hold_idx", {60'd0, idx_out}, {60'd0, hold_i});
            chk("hold_last", {63'd0, last_flag_out}, {63'd0, hold_l});
         end
         if (payload_ready) begin
            chk("pready_after_hdr", 64'(out_d.size() + (data_valid_out ? 1 : 0) >= 3), 64'd1);
         end
         if (data_valid_out && !tx_ready_in) begin
            chk("stall_pready", {63'd0, payload_ready}, 64'd0);
            hold_v = 1; hold_d = tdata_out; hold_i = idx_out; hold_l = last_flag_out;
         end else begin
            hold_v = 0;
         end
         if (data_valid_out && hcyc >= 0 && fcyc < 0) fcyc = c;
         if (data_valid_out && tx_ready_in) begin
            out_d.push_back(tdata_out); out_i.push_back(idx_out); out_l.push_back(last_flag_out);
            if (last_flag_out) done = 1;
         end
         hdr_fire = hdr_valid_in && hdr_ready_out;
         pay_fire = data_valid_in && payload_ready;
         if (hdr_fire) hcyc = c;
         if (abort_after >= 0 && out_d.size() == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            chk("abort_tdata", tdata_out, 64'd0);
            chk("abort_idx", {60'd0, idx_out}, 64'd0);
            chk("abort_valid", {63'd0, data_valid_out}, 64'd0);
            chk("abort_last", {63'd0, last_flag_out}, 64'd0);
            chk("abort_hready", {63'd0, hdr_ready_out}, 64'd0);
            chk("abort_pready", {63'd0, payload_ready}, 64'd0);
            hdr_valid_in = 1'b0; data_valid_in = 1'b0; last_flag_in = 1'b0;
            #1 rst_n = 1'b1;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
         if (hdr_fire) hdr_valid_in = 1'b0;
         if (pay_fire) pi++;
         data_valid_in = (pi < npay);
         tdata_in      = pay_data[pi < 16 ? pi : 0];
         idx_in        = pay_idx[pi < 16 ? pi : 0];
         last_flag_in  = (pi == npay - 1);
         rel = c + 1 - hcyc;
         rdy = 1'b1;
         if (hcyc >= 0 && v.s1 >= 0 && rel >= v.s1 && rel < v.s1 + 5) rdy = 1'b0;
         if (hcyc >= 0 && v.s2 >= 0 && rel >= v.s2 && rel < v.s2 + 5) rdy = 1'b0;
         tx_ready_in = rdy;
      end
      if (!done) chk("packet_timeout", 64'd0, 64'd1);
      tx_ready_in = 1'b1;
   endtask

   task automatic check_packet(input vec_t v, input string tag);
      logic [15:0] cs;
      logic [63:0] e;
      logic [3:0]  ei;
      logic        el;
      int          nexp, j;
      cs   = CSUM_ON ? v.csum : 16'h0000;
      nexp = 3 + npay;
      chk({tag, "_nbeats"}, 64'(out_d.size()), 64'(nexp));
      chk({tag, "_latency"}, 64'(fcyc - hcyc), 64'(LAT));
      for (int b = 0; b < out_d.size() && b < nexp; b++) begin
         if (b < 3) begin
            ei = (b == 2) ? 4'd4 : 4'd8;
            e  = '0;
            for (int i = 0; i < int'(ei); i++) e[i*8 +: 8] = hbyte(b * 8 + i, v, cs);
            el = (b == 2) && (v.len == 16'd0);
         end else begin
            j  = b - 3;
            ei = pay_idx[j];
            e  = pay_data[j] & lane_mask(ei);
            el = (j == npay - 1);
         end
         chk({tag, "_data"}, out_d[b] & lane_mask(ei), e);
         chk({tag, "_idx"}, {60'd0, out_i[b]}, {60'd0, ei});
         chk({tag, "_last"}, {63'd0, out_l[b]}, {63'd0, el});
      end
   endtask

   task automatic check_first_vector(input string tag);
      if (out_d.size() >= 3) begin
         chk({tag, "_beat0"}, out_d[0], 64'h0040_0000_1C00_0045);
         chk({tag, "_beat1"}, out_d[1], CSUM_ON ? 64'h0A01_A8C0_75B7_1140 : 64'h0A01_A8C0_0000_1140);
         chk({tag, "_beat2"}, {32'd0, out_d[2][31:0]}, 64'h0000_0000_0101_A8C0);
      end else begin
         chk({tag, "_beats_present"}, 64'(out_d.size()), 64'd3);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //        src           dst           proto  len       pbytes mid s1  s2  ident    csum
      tv[0] = '{32'hC0A8010A, 32'hC0A80101, 8'h11, 16'd8,      8,     0, -1, -1, 16'h0000, 16'hB775};
      tv[1] = '{32'hC0A8010A, 32'hC0A80101, 8'h11, 16'd0,      0,     0, -1, -1, 16'h0001, 16'hB77C};
      tv[2] = '{32'h0A000001, 32'h0A000002, 8'h06, 16'd20,     20,    0,  4, 12, 16'h0002, 16'h26CC};
      tv[3] = '{32'hFFFFFFFF, 32'h00000000, 8'h01, 16'hFFF0,   5,     0, -1, -1, 16'h0003, 16'h3AF7};
      tv[4] = '{32'h01020304, 32'h05060708, 8'h11, 16'd11,     11,    1, -1, -1, 16'h0004, 16'h2AB7};

      rst_n = 1'b0; hdr_valid_in = 1'b0; src_ip = '0; dst_ip = '0; protocol = '0;
      payload_len = '0; tdata_in = '0; idx_in = '0; data_valid_in = 1'b0;
      last_flag_in = 1'b0; tx_ready_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tdata", tdata_out, 64'd0);
      chk("rst_idx", {60'd0, idx_out}, 64'd0);
      chk("rst_valid", {63'd0, data_valid_out}, 64'd0);
      chk("rst_last", {63'd0, last_flag_out}, 64'd0);
      chk("rst_hready", {63'd0, hdr_ready_out}, 64'd0);
      chk("rst_pready", {63'd0, payload_ready}, 64'd0);
      rst_n = 1'b1;
      #1 chk("hready_before_edge", {63'd0, hdr_ready_out}, 64'd0);
      @(posedge clk); #1;
      chk("hready_after_edge", {63'd0, hdr_ready_out}, 64'd1);

      for (int r = 0; r < 5; r++) begin
         build_payload(tv[r].pbytes, tv[r].mid_part, r * 16);
         run_packet(tv[r], -1);
         check_packet(tv[r], $sformatf("vec%0d", r));
         if (r == 0) check_first_vector("vec0");
         if (r == 1) chk("len0_hready", {63'd0, hdr_ready_out}, 64'd1);
      end

      // Ident wrap: preload the counter to 0xFFFF while idle.
      force dut.ident_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.ident_q;
      vw = '{32'h00000000, 32'h00000000, 8'h00, 16'd0, 0, 0, -1, -1, 16'hFFFF, 16'h3AEB};
      build_payload(0, 0, 0);
      run_packet(vw, -1);
      check_packet(vw, "wrap_ffff");
      vw.ident = 16'h0000;
      run_packet(vw, -1);
      check_packet(vw, "wrap_0000");

      // Reset while the first payload beat is on the output.
      vw = '{32'h0A0A0A0A, 32'h0B0B0B0B, 8'h11, 16'd16, 16, 0, -1, -1, 16'h0000, 16'h0000};
      build_payload(16, 0, 99);
      run_packet(vw, 4);
      chk("post_abort_hready", {63'd0, hdr_ready_out}, 64'd1);
      build_payload(tv[0].pbytes, tv[0].mid_part, 5);
      run_packet(tv[0], -1);
      check_packet(tv[0], "post_abort");
      check_first_vector("post_abort");

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
